// File: rtl/led_scan_if.sv
// Bundles the frame-buffer read port, the LED pin group and the status
// outputs of the LED scan sequencer.
// Read port timing: fb_data must present the word at fb_addr exactly one
// clock after fb_addr changes, and hold it while fb_addr is unchanged.
// There is no valid/ready pairing. The controller owns the address, and the
// memory side answers with a fixed one-cycle latency.
interface led_scan_if #(
  parameter int COLS = 64,
  parameter int BITS = 8
);
  localparam int AW = $clog2(BITS) + 4 + $clog2(COLS);

  logic          en;
  logic [AW-1:0] fb_addr;
  logic [23:0]   fb_data;
  logic [23:0]   led_data;
  logic          LED_CLK;
  logic          LED_LT;
  logic          LED_OE;
  logic [3:0]    LED_A;
  logic          busy;
  logic          frame_done;
  logic [2:0]    state_dbg;

  modport master (
    input  en, fb_data,
    output fb_addr, led_data, LED_CLK, LED_LT, LED_OE, LED_A, busy,
           frame_done, state_dbg
  );

  modport slave (
    output en, fb_data,
    input  fb_addr, led_data, LED_CLK, LED_LT, LED_OE, LED_A, busy,
           frame_done, state_dbg
  );
endinterface

// File: rtl/led_scan_ctrl.sv
// HUB75-style scan sequencer for four panels. Rows are scanned 0..15 in the
// outer loop and bit planes 0..BITS-1 in the inner loop. Each row-plane unit
// goes through prefetch, shift, wait, blank and latch. A free-running on-timer
// applies the BCM on-time of the previously latched plane while the next
// plane is being shifted in.
module led_scan_ctrl #(
  parameter int COLS    = 64,
  parameter int BITS    = 8,
  parameter int OE_BASE = 8
) (
  input  logic FPGA_CLK0,
  input  logic FPGA_RST,
  led_scan_if.master bus
);
  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(BITS);
  localparam int AW = PW + 4 + CW;
  localparam int TW = $clog2(OE_BASE) + BITS;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREFETCH = 3'd1,
    S_SHIFT    = 3'd2,
    S_WAIT     = 3'd3,
    S_BLANK    = 3'd4,
    S_LATCH    = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic            phase_q, phase_d;
  logic [3:0]      row_q, row_d;
  logic [PW-1:0]   plane_q, plane_d;
  logic [AW-1:0]   fb_addr_q, fb_addr_d;
  logic [23:0]     led_data_q, led_data_d;
  logic            led_clk_q, led_clk_d;
  logic            led_lt_q, led_lt_d;
  logic [3:0]      led_a_q, led_a_d;
  logic            frame_done_q, frame_done_d;
  logic [TW-1:0]   timer_q;

  logic last_plane;
  logic last_unit;
  logic timer_ends;

  assign last_plane = (plane_q == PW'(BITS - 1));
  assign last_unit  = last_plane && (row_q == 4'd15);
  // The on-time is over by the next cycle: the timer is already 0, or it is 1
  // and reaches 0 on this edge. Leaving for BLANK here makes BLANK the first
  // dark cycle.
  assign timer_ends = (timer_q <= TW'(1));

  // State and registered pin outputs.
  always_ff @(posedge FPGA_CLK0) begin
    if (FPGA_RST) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      phase_q      <= 1'b0;
      row_q        <= '0;
      plane_q      <= '0;
      fb_addr_q    <= '0;
      led_data_q   <= '0;
      led_clk_q    <= 1'b0;
      led_lt_q     <= 1'b0;
      led_a_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      phase_q      <= phase_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      fb_addr_q    <= fb_addr_d;
      led_data_q   <= led_data_d;
      led_clk_q    <= led_clk_d;
      led_lt_q     <= led_lt_d;
      led_a_q      <= led_a_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state and next-output logic. Each pin value set here appears one
  // cycle later, so data loaded in the even phase shows one cycle before the
  // LED_CLK rise set in the odd phase.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    phase_d      = phase_q;
    row_d        = row_q;
    plane_d      = plane_q;
    fb_addr_d    = fb_addr_q;
    led_data_d   = led_data_q;
    led_clk_d    = 1'b0;
    led_lt_d     = 1'b0;
    led_a_d      = led_a_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          fb_addr_d = {plane_q, row_q, CW'(0)};
          state_d   = S_PREFETCH;
        end
      end
      S_PREFETCH: begin
        col_d   = '0;
        phase_d = 1'b0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (!phase_q) begin
          led_data_d = bus.fb_data;
          fb_addr_d  = {plane_q, row_q, col_q + CW'(1)};
          phase_d    = 1'b1;
        end else begin
          led_clk_d = 1'b1;
          phase_d   = 1'b0;
          col_d     = col_q + CW'(1);
          if (col_q == CW'(COLS - 1)) begin
            state_d = timer_ends ? S_BLANK : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (timer_ends) begin
          state_d = S_BLANK;
        end
      end
      S_BLANK: begin
        led_lt_d = 1'b1;
        led_a_d  = row_q;
        state_d  = S_LATCH;
      end
      S_LATCH: begin
        if (last_plane) begin
          plane_d = '0;
          row_d   = row_q + 4'd1;
        end else begin
          plane_d = plane_q + PW'(1);
        end
        fb_addr_d    = {plane_d, row_d, CW'(0)};
        frame_done_d = last_unit;
        state_d      = (last_unit && !bus.en) ? S_IDLE : S_PREFETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // BCM on-timer: loaded at latch with the on-time of the plane just latched,
  // then counts down to 0 regardless of the sequencer state.
  always_ff @(posedge FPGA_CLK0) begin
    if (FPGA_RST) begin
      timer_q <= '0;
    end else if (state_q == S_LATCH) begin
      timer_q <= TW'(OE_BASE) << plane_q;
    end else if (timer_q != '0) begin
      timer_q <= timer_q - TW'(1);
    end
  end

  assign bus.fb_addr    = fb_addr_q;
  assign bus.led_data   = led_data_q;
  assign bus.LED_CLK    = led_clk_q;
  assign bus.LED_LT     = led_lt_q;
  assign bus.LED_OE     = (timer_q == '0);
  assign bus.LED_A      = led_a_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = frame_done_q;
  assign bus.state_dbg  = state_q;
endmodule
